// File: rtl/riscv_pkg.sv
// Shared RV32I definitions: word type, formats, opcodes and immediate range helpers.
package riscv_pkg;

  typedef logic [31:0] bus32_t;

  typedef enum logic [2:0] {
    FMT_R, FMT_I, FMT_S, FMT_B, FMT_U, FMT_J, FMT_CSR, FMT_BAD
  } fmt_e;

  localparam logic [6:0] OP_LUI    = 7'h37;
  localparam logic [6:0] OP_AUIPC  = 7'h17;
  localparam logic [6:0] OP_ALU_I  = 7'h13;
  localparam logic [6:0] OP_ALU    = 7'h33;
  localparam logic [6:0] OP_LW     = 7'h03;
  localparam logic [6:0] OP_SW     = 7'h23;
  localparam logic [6:0] OP_BRANCH = 7'h63;
  localparam logic [6:0] OP_JAL    = 7'h6F;
  localparam logic [6:0] OP_JALR   = 7'h67;
  localparam logic [6:0] OP_CSR    = 7'h73;

  // Encoded word plus its error flag, as stored in the output FIFO.
  typedef struct packed {
    logic   err;
    bus32_t instr;
  } enc_rsp_t;

  // True when v[31:msb] are all equal, i.e. v fits a signed field of msb+1 bits.
  function automatic logic sext_ok(input bus32_t v, input int unsigned msb);
    bus32_t t;
    t = bus32_t'($signed(v) >>> msb);
    return (t == '0) || (t == '1);
  endfunction

endpackage

// File: rtl/instr_fifo.sv
// Small synchronous FIFO with valid/ready on both sides; head entry always visible.
module instr_fifo #(
  parameter int DEPTH = 2,
  parameter int W     = 33
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         push_valid_i,
  output logic         push_ready_o,
  input  logic [W-1:0] push_data_i,
  output logic         pop_valid_o,
  input  logic         pop_ready_i,
  output logic [W-1:0] pop_data_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [AW:0]   r_cnt;
  logic          w_push;
  logic          w_pop;

  assign push_ready_o = (r_cnt != FULL_CNT);
  assign pop_valid_o  = (r_cnt != '0);
  assign pop_data_o   = r_mem[r_rptr];
  assign w_push       = push_valid_i & push_ready_o;
  assign w_pop        = pop_ready_i & pop_valid_o;

  // Storage, pointers (wrap naturally, DEPTH is a power of two) and occupancy.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_wptr <= '0;
      r_rptr <= '0;
      r_cnt  <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wptr] <= push_data_i;
        r_wptr        <= r_wptr + 1'b1;
      end
      if (w_pop) r_rptr <= r_rptr + 1'b1;
      r_cnt <= r_cnt + (AW+1)'(w_push) - (AW+1)'(w_pop);
    end
  end

endmodule

// File: rtl/instr_encoder.sv
// Packs RV32I fields and an immediate into an instruction word, flags bad immediates,
// and buffers {instr,err} in a small FIFO. Keeps push/error statistics.
module instr_encoder
  import riscv_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             req_valid_i,
  output logic             req_ready_o,
  input  logic [6:0]       req_opcode_i,
  input  logic [4:0]       req_rd_i,
  input  logic [4:0]       req_rs1_i,
  input  logic [4:0]       req_rs2_i,
  input  logic [2:0]       req_funct3_i,
  input  logic [6:0]       req_funct7_i,
  input  logic [31:0]      req_imm_i,
  output logic             rsp_valid_o,
  input  logic             rsp_ready_i,
  output logic [31:0]      rsp_instr_o,
  output logic             rsp_err_o,
  output logic [CNT_W-1:0] enc_cnt_o,
  output logic [CNT_W-1:0] err_cnt_o
);

  bus32_t           w_instr;
  logic             w_err;
  enc_rsp_t         w_enc;
  enc_rsp_t         w_head;
  logic             w_push;
  logic [CNT_W-1:0] r_enc_cnt;
  logic [CNT_W-1:0] r_err_cnt;

  // Field packing and range/alignment check per opcode; bad words keep their truncated encoding.
  always_comb begin
    w_instr = '0;
    w_err   = 1'b0;
    case (req_opcode_i)
      OP_LUI, OP_AUIPC: begin
        w_instr = {req_imm_i[31:12], req_rd_i, req_opcode_i};
        w_err   = |req_imm_i[11:0];
      end
      OP_ALU_I: begin
        w_instr = {req_imm_i[11:0], req_rs1_i, req_funct3_i, req_rd_i, req_opcode_i};
        w_err   = !sext_ok(req_imm_i, 11);
        // slli/srli/srai: upper imm bits carry only the srai selector
        if (req_funct3_i[1:0] == 2'b01)
          w_err = w_err | ((req_imm_i[11:5] != 7'h00) && (req_imm_i[11:5] != 7'h20));
      end
      OP_LW, OP_JALR: begin
        w_instr = {req_imm_i[11:0], req_rs1_i, req_funct3_i, req_rd_i, req_opcode_i};
        w_err   = !sext_ok(req_imm_i, 11);
      end
      OP_CSR: begin
        w_instr = {req_imm_i[11:0], req_rs1_i, req_funct3_i, req_rd_i, req_opcode_i};
        w_err   = |req_imm_i[31:12];
      end
      OP_SW: begin
        w_instr = {req_imm_i[11:5], req_rs2_i, req_rs1_i, req_funct3_i, req_imm_i[4:0],
                   req_opcode_i};
        w_err   = !sext_ok(req_imm_i, 11);
      end
      OP_BRANCH: begin
        w_instr = {req_imm_i[12], req_imm_i[10:5], req_rs2_i, req_rs1_i, req_funct3_i,
                   req_imm_i[4:1], req_imm_i[11], req_opcode_i};
        w_err   = !sext_ok(req_imm_i, 12) | req_imm_i[0];
      end
      OP_JAL: begin
        w_instr = {req_imm_i[20], req_imm_i[10:1], req_imm_i[11], req_imm_i[19:12],
                   req_rd_i, req_opcode_i};
        w_err   = !sext_ok(req_imm_i, 20) | req_imm_i[0];
      end
      OP_ALU: begin
        w_instr = {req_funct7_i, req_rs2_i, req_rs1_i, req_funct3_i, req_rd_i, req_opcode_i};
      end
      default: begin
        w_instr = '0;
        w_err   = 1'b1;
      end
    endcase
  end

  assign w_enc.err   = w_err;
  assign w_enc.instr = w_instr;
  assign w_push      = req_valid_i & req_ready_o;

  instr_fifo #(
    .DEPTH (DEPTH),
    .W     ($bits(enc_rsp_t))
  ) u_fifo (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .push_valid_i (req_valid_i),
    .push_ready_o (req_ready_o),
    .push_data_i  (w_enc),
    .pop_valid_o  (rsp_valid_o),
    .pop_ready_i  (rsp_ready_i),
    .pop_data_o   (w_head)
  );

  assign rsp_instr_o = w_head.instr;
  assign rsp_err_o   = w_head.err;

  // Saturating statistics, counted on every accepted push.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_enc_cnt <= '0;
      r_err_cnt <= '0;
    end else if (w_push) begin
      if (r_enc_cnt != '1)          r_enc_cnt <= r_enc_cnt + 1'b1;
      if (w_err && r_err_cnt != '1) r_err_cnt <= r_err_cnt + 1'b1;
    end
  end

  assign enc_cnt_o = r_enc_cnt;
  assign err_cnt_o = r_err_cnt;

endmodule
